// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter for chroni: display fetch has priority, the CPU gets a
// forced slot after CPU_MAX_WAIT denied cycles, and lost display slots are counted.
module chroni_vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int CPU_MAX_WAIT = 8,
    parameter int MISS_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_grant,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_grant,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              miss_clr,
    output logic [MISS_W-1:0] disp_miss_count
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    localparam logic [7:0]        MAX_WAIT = 8'(CPU_MAX_WAIT);
    localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    tag_e              tag1_q, tag1_d, tag2_q, tag2_d;
    logic              force_cpu;
    logic              disp_miss;

    // Grants are purely combinational so a requester learns of acceptance in the same cycle.
    assign force_cpu  = cpu_req && (wait_cnt_q == MAX_WAIT);
    assign cpu_grant  = cpu_req && (force_cpu || !disp_req);
    assign disp_grant = disp_req && !force_cpu;
    assign disp_miss  = disp_req && !disp_grant;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        wait_cnt_d  = wait_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        miss_d      = miss_q;
        tag1_d      = TAG_NONE;
        tag2_d      = tag1_q;

        if (!cpu_req || cpu_grant) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != MAX_WAIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if (disp_grant) begin
            mem_addr_d = disp_addr;
            tag1_d     = TAG_DISP;
        end else if (cpu_grant) begin
            mem_addr_d  = cpu_addr;
            mem_we_d    = cpu_we;
            mem_wdata_d = cpu_wdata;
            tag1_d      = cpu_we ? TAG_NONE : TAG_CPU;
        end

        if (miss_clr) begin
            miss_d = '0;
        end else if (disp_miss && !(&miss_q)) begin
            miss_d = miss_q + MISS_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= 8'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            miss_q      <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            miss_q      <= miss_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
        end
    end

    // Read data is shared; only the valid strobes say whose data it is.
    assign mem_addr        = mem_addr_q;
    assign mem_we          = mem_we_q;
    assign mem_wdata       = mem_wdata_q;
    assign disp_rvalid     = (tag2_q == TAG_DISP);
    assign cpu_rvalid      = (tag2_q == TAG_CPU);
    assign disp_rdata      = mem_rdata;
    assign cpu_rdata       = mem_rdata;
    assign disp_miss_count = miss_q;

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Randomized and directed bench for chroni_vram_arbiter, checked against a
// transaction-level model of grants, read returns and the miss counter.
module tb_chroni_vram_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int MAXW = 4;
    localparam int MW   = 8;
    localparam logic [MW-1:0] MISS_MAX = '1;

    logic          clk, reset_n;
    logic          disp_req, disp_grant, disp_rvalid;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req, cpu_we, cpu_grant, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          miss_clr;
    logic [MW-1:0] disp_miss_count;

    chroni_vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .CPU_MAX_WAIT(MAXW), .MISS_W(MW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_grant(disp_grant),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .miss_clr(miss_clr), .disp_miss_count(disp_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous memory macro; powers up holding addr[7:0].
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
    end

    // Reference model state.
    typedef struct {
        int            due;
        bit            is_cpu;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           pend[$];
    logic [DW-1:0] ref_mem [0:65535];
    int            m_wait;
    logic [MW-1:0] m_miss;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    int            cyc;

    logic          e_dg, e_cg, e_drv, e_crv, e_mwe;
    logic [DW-1:0] e_dd, e_cd, e_mwd;
    logic [AW-1:0] e_maddr;
    logic [MW-1:0] e_miss;
    logic          o_dg, o_cg, o_drv, o_crv, o_mwe;
    logic [DW-1:0] o_dd, o_cd, o_mwd;
    logic [AW-1:0] o_maddr;
    logic [MW-1:0] o_miss;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        pend.delete();
        m_wait  = 0;
        m_miss  = '0;
        m_addr  = '0;
        m_we    = 1'b0;
        m_wdata = '0;
    endtask

    // Advance one cycle: sample DUT mid-cycle, form expectations, update the model.
    task automatic tick();
        bit   forced;
        rd_t  p;
        @(negedge clk);
        forced = cpu_req && (m_wait == MAXW);
        e_cg   = cpu_req && (forced || !disp_req);
        e_dg   = disp_req && !forced;
        e_drv  = 1'b0;
        e_crv  = 1'b0;
        e_dd   = '0;
        e_cd   = '0;
        while (pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            if (p.due == cyc) begin
                if (p.is_cpu) begin e_crv = 1'b1; e_cd = p.data; end
                else          begin e_drv = 1'b1; e_dd = p.data; end
            end
        end
        e_maddr = m_addr;
        e_mwe   = m_we;
        e_mwd   = m_wdata;
        e_miss  = m_miss;
        o_dg = disp_grant; o_cg = cpu_grant; o_drv = disp_rvalid; o_crv = cpu_rvalid;
        o_dd = disp_rdata; o_cd = cpu_rdata; o_maddr = mem_addr; o_mwe = mem_we;
        o_mwd = mem_wdata; o_miss = disp_miss_count;

        m_we = 1'b0;
        if (e_dg) begin
            pend.push_back('{due: cyc + 2, is_cpu: 1'b0, data: ref_mem[disp_addr]});
            m_addr = disp_addr;
        end else if (e_cg) begin
            m_addr = cpu_addr;
            if (cpu_we) begin
                ref_mem[cpu_addr] = cpu_wdata;
                m_we    = 1'b1;
                m_wdata = cpu_wdata;
            end else begin
                pend.push_back('{due: cyc + 2, is_cpu: 1'b1, data: ref_mem[cpu_addr]});
            end
        end
        if (miss_clr)                                  m_miss = '0;
        else if (disp_req && !e_dg && m_miss != MISS_MAX) m_miss = m_miss + 1'b1;
        if (!cpu_req || e_cg) m_wait = 0;
        else if (m_wait < MAXW) m_wait = m_wait + 1;

        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic idle_inputs();
        disp_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; miss_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        idle_inputs();
        disp_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        #1 reset_n = 1'b0;
        #2;
        n_checks++;
        if ({mem_addr, mem_we, mem_wdata, disp_rvalid, cpu_rvalid, disp_miss_count} !== '0 ||
            disp_grant !== 1'b0 || cpu_grant !== 1'b0)
            $display("FAIL reset_state addr=%h we=%b wd=%h drv=%b crv=%b miss=%h dg=%b cg=%b want all 0",
                     mem_addr, mem_we, mem_wdata, disp_rvalid, cpu_rvalid, disp_miss_count,
                     disp_grant, cpu_grant);
        else n_pass++;
        disp_req = 1'b1; cpu_req = 1'b1;
        #1;
        n_checks++;
        if (disp_grant !== 1'b1 || cpu_grant !== 1'b0)
            $display("FAIL reset_comb_grants dg=%b cg=%b want dg=1 cg=0", disp_grant, cpu_grant);
        else n_pass++;
        disp_req = 1'b0;
        #1;
        n_checks++;
        if (cpu_grant !== 1'b1 || disp_grant !== 1'b0)
            $display("FAIL reset_cpu_alone cg=%b dg=%b want cg=1 dg=0", cpu_grant, disp_grant);
        else n_pass++;
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_display_burst();
        logic [DW-1:0] want;
        disp_addr = 16'h0010;
        for (int k = 0; k < 18; k++) begin
            disp_req = (k < 16);
            tick();
            want = 8'h10 + 8'(k - 2);
            n_checks++;
            if ((k < 16 && o_dg !== 1'b1) || o_crv !== 1'b0 || o_cg !== 1'b0)
                $display("FAIL burst_grant k=%0d dg=%b cg=%b crv=%b", k, o_dg, o_cg, o_crv);
            else n_pass++;
            n_checks++;
            if (k >= 2 ? (o_drv !== 1'b1 || o_dd !== want) : (o_drv !== 1'b0))
                $display("FAIL burst_rdata k=%0d rvalid=%b data=%h want rvalid=%b data=%h",
                         k, o_drv, o_dd, (k >= 2), want);
            else n_pass++;
            if (o_dg) disp_addr = disp_addr + 16'd1;
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'hA5;
        tick();
        n_checks++;
        if (o_cg !== 1'b1) $display("FAIL wr_grant cg=%b want 1", o_cg);
        else n_pass++;
        cpu_we = 1'b0; cpu_wdata = 8'h00;
        tick();
        n_checks++;
        if (o_mwe !== 1'b1 || o_maddr !== 16'h0400 || o_mwd !== 8'hA5 || o_cg !== 1'b1)
            $display("FAIL wr_issue we=%b addr=%h wd=%h cg=%b want 1/0400/a5/1",
                     o_mwe, o_maddr, o_mwd, o_cg);
        else n_pass++;
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if (o_mwe !== 1'b0 || o_crv !== 1'b0 || o_drv !== 1'b0)
            $display("FAIL wr_one_cycle we=%b crv=%b drv=%b want 0/0/0", o_mwe, o_crv, o_drv);
        else n_pass++;
        tick();
        n_checks++;
        if (o_crv !== 1'b1 || o_cd !== 8'hA5 || o_drv !== 1'b0)
            $display("FAIL rd_after_wr crv=%b data=%h drv=%b want 1/a5/0", o_crv, o_cd, o_drv);
        else n_pass++;
        tick();
        n_checks++;
        if (o_crv !== 1'b0) $display("FAIL rd_single_valid crv=%b want 0", o_crv);
        else n_pass++;
    endtask

    task automatic test_contention();
        miss_clr = 1'b1;
        tick();
        miss_clr = 1'b0;
        disp_addr = 16'h0100; cpu_addr = 16'h0200; cpu_we = 1'b0;
        for (int k = 0; k < 15; k++) begin
            disp_req = 1'b1; cpu_req = 1'b1;
            tick();
            n_checks++;
            if (o_cg !== (k % 5 == 4) || o_dg !== (k % 5 != 4))
                $display("FAIL contention_grant k=%0d dg=%b cg=%b want dg=%b cg=%b",
                         k, o_dg, o_cg, (k % 5 != 4), (k % 5 == 4));
            else n_pass++;
            n_checks++;
            if (o_drv !== e_drv || o_crv !== e_crv || (e_drv && o_dd !== e_dd) ||
                (e_crv && o_cd !== e_cd))
                $display("FAIL contention_rd k=%0d drv=%b crv=%b want %b %b",
                         k, o_drv, o_crv, e_drv, e_crv);
            else n_pass++;
            if (k == 5) begin
                n_checks++;
                if (o_miss !== 8'd1) $display("FAIL contention_miss1 got=%0d want 1", o_miss);
                else n_pass++;
            end
            if (o_dg) disp_addr = disp_addr + 16'd1;
        end
        idle_inputs();
        tick();
        n_checks++;
        if (o_miss !== 8'd3) $display("FAIL contention_miss3 got=%0d want 3", o_miss);
        else n_pass++;
    endtask

    task automatic test_withdrawal();
        disp_addr = 16'h0300; cpu_addr = 16'h0210; cpu_we = 1'b0;
        for (int k = 0; k < 9; k++) begin
            disp_req = 1'b1;
            cpu_req  = (k != 3);
            miss_clr = (k == 0);
            tick();
            n_checks++;
            if (o_cg !== (k == 8) || (k >= 1 && o_miss !== 8'd0))
                $display("FAIL withdraw k=%0d cg=%b miss=%0d want cg=%b miss=0",
                         k, o_cg, o_miss, (k == 8));
            else n_pass++;
            if (o_dg) disp_addr = disp_addr + 16'd1;
        end
        idle_inputs();
        tick();
        n_checks++;
        if (o_miss !== 8'd1) $display("FAIL withdraw_miss got=%0d want 1", o_miss);
        else n_pass++;
    endtask

    task automatic test_miss_saturation();
        disp_addr = 16'h0500; cpu_addr = 16'h0600; cpu_we = 1'b0;
        for (int k = 0; k < 5 * 260; k++) begin
            disp_req = 1'b1; cpu_req = 1'b1;
            tick();
            n_checks++;
            if (o_miss !== e_miss || o_cg !== e_cg || o_dg !== e_dg)
                $display("FAIL sat_run k=%0d miss=%0d cg=%b want miss=%0d cg=%b",
                         k, o_miss, o_cg, e_miss, e_cg);
            else n_pass++;
        end
        idle_inputs();
        tick();
        n_checks++;
        if (o_miss !== 8'hFF) $display("FAIL sat_hold got=%h want ff", o_miss);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            disp_req = 1'b1; cpu_req = 1'b1; miss_clr = (k == 4);
            tick();
        end
        n_checks++;
        if (o_cg !== 1'b1 || o_dg !== 1'b0)
            $display("FAIL clr_force_slot cg=%b dg=%b want 1/0", o_cg, o_dg);
        else n_pass++;
        idle_inputs();
        tick();
        n_checks++;
        if (o_miss !== 8'h00) $display("FAIL clr_priority got=%h want 00", o_miss);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        disp_req = 1'b1; disp_addr = 16'h0055;
        tick();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_addr !== '0 || disp_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || mem_we !== 1'b0)
            $display("FAIL midreset_async addr=%h drv=%b crv=%b we=%b want 0", mem_addr,
                     disp_rvalid, cpu_rvalid, mem_we);
        else n_pass++;
        #1 reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o_drv !== 1'b0 || o_crv !== 1'b0)
                $display("FAIL midreset_stale k=%0d drv=%b crv=%b want 0", k, o_drv, o_crv);
            else n_pass++;
        end
        disp_req = 1'b1; disp_addr = 16'h0033;
        tick();
        disp_req = 1'b0;
        tick();
        n_checks++;
        if (o_maddr !== 16'h0033 || o_drv !== 1'b0)
            $display("FAIL midreset_issue addr=%h drv=%b want 0033/0", o_maddr, o_drv);
        else n_pass++;
        tick();
        n_checks++;
        if (o_drv !== 1'b1 || o_dd !== 8'h33)
            $display("FAIL midreset_next rvalid=%b data=%h want 1/33", o_drv, o_dd);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            tick();
            n_checks++;
            if (o_dg !== e_dg || o_cg !== e_cg)
                $display("FAIL rnd_grant cyc=%0d dg=%b cg=%b want dg=%b cg=%b",
                         cyc, o_dg, o_cg, e_dg, e_cg);
            else n_pass++;
            n_checks++;
            if (o_drv !== e_drv || o_crv !== e_crv || (e_drv && o_dd !== e_dd) ||
                (e_crv && o_cd !== e_cd))
                $display("FAIL rnd_rdata cyc=%0d drv=%b dd=%h crv=%b cd=%h want %b %h %b %h",
                         cyc, o_drv, o_dd, o_crv, o_cd, e_drv, e_dd, e_crv, e_cd);
            else n_pass++;
            n_checks++;
            if (o_maddr !== e_maddr || o_mwe !== e_mwe || (e_mwe && o_mwd !== e_mwd))
                $display("FAIL rnd_issue cyc=%0d addr=%h we=%b wd=%h want %h %b %h",
                         cyc, o_maddr, o_mwe, o_mwd, e_maddr, e_mwe, e_mwd);
            else n_pass++;
            n_checks++;
            if (o_miss !== e_miss)
                $display("FAIL rnd_miss cyc=%0d got=%0d want %0d", cyc, o_miss, e_miss);
            else n_pass++;

            // Requests hold until granted, may drop early, then take fresh values.
            if ((disp_req && o_dg) || (disp_req && $urandom_range(0, 9) == 0)) disp_req = 1'b0;
            else if (!disp_req && $urandom_range(0, 3) != 0) begin
                disp_req  = 1'b1;
                disp_addr = 16'h0800 + 16'($urandom_range(0, 31));
            end
            if ((cpu_req && o_cg) || (cpu_req && $urandom_range(0, 15) == 0)) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 1) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 16'h0800 + 16'($urandom_range(0, 31));
                cpu_wdata = 8'($urandom);
            end
            miss_clr = ($urandom_range(0, 40) == 0);
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i);
            ref_mem[i] = 8'(i);
        end
        cyc = 0;
        test_reset();
        test_display_burst();
        test_write_read();
        test_contention();
        test_withdrawal();
        test_miss_saturation();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout cyc=%0d limit reached", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
